// File: rtl/ras_ctrl_if.sv
// Dispatch / RAS / CDB / redirect bundle for ras_ctrl.
// The master drives requests and results; the slave is the controller.
interface ras_ctrl_if #(
  parameter int unsigned RAS_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = 5
);
  logic                 du_jal_req;
  logic [RAS_WIDTH-1:0] du_jal_ret_addr;
  logic                 du_jal_ready;
  logic                 du_jr31_req;
  logic [TAG_WIDTH-1:0] du_jr31_rob_tag;
  logic                 du_jr31_ready;
  logic [RAS_WIDTH-1:0] du_jr31_pred_addr;
  logic                 du_jr31_pred_valid;
  logic                 ras_push;
  logic [RAS_WIDTH-1:0] ras_push_din;
  logic                 ras_pop;
  logic [RAS_WIDTH-1:0] ras_top_dout;
  logic                 cdb_jr31_valid;
  logic [TAG_WIDTH-1:0] cdb_jr31_rob_tag;
  logic [RAS_WIDTH-1:0] cdb_jr31_target;
  logic                 cdb_flush;
  logic                 ctrl_mispredict;
  logic [RAS_WIDTH-1:0] ctrl_redirect_addr;
  logic                 ctrl_trk_full;

  modport master (
    output du_jal_req, du_jal_ret_addr, du_jr31_req, du_jr31_rob_tag, ras_top_dout,
           cdb_jr31_valid, cdb_jr31_rob_tag, cdb_jr31_target, cdb_flush,
    input  du_jal_ready, du_jr31_ready, du_jr31_pred_addr, du_jr31_pred_valid, ras_push,
           ras_push_din, ras_pop, ctrl_mispredict, ctrl_redirect_addr, ctrl_trk_full
  );

  modport slave (
    input  du_jal_req, du_jal_ret_addr, du_jr31_req, du_jr31_rob_tag, ras_top_dout,
           cdb_jr31_valid, cdb_jr31_rob_tag, cdb_jr31_target, cdb_flush,
    output du_jal_ready, du_jr31_ready, du_jr31_pred_addr, du_jr31_pred_valid, ras_push,
           ras_push_din, ras_pop, ctrl_mispredict, ctrl_redirect_addr, ctrl_trk_full
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack front-end controller: issues ras push/pop for jal/jr31, tracks in-flight
// jr31 predictions by ROB tag and flags mispredicts against the CDB-resolved target.
module ras_ctrl #(
  parameter int unsigned RAS_WIDTH   = 32,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter int unsigned TRK_DEPTH   = 4,
  parameter int unsigned TAG_WIDTH   = 5,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  ras_ctrl_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(RAS_DEPTH + 1);
  localparam int unsigned RcW   = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int unsigned SlotW = (TRK_DEPTH > 1) ? $clog2(TRK_DEPTH) : 1;

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e               state_q, state_d;
  logic [RcW-1:0]       rc_q, rc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TRK_DEPTH-1:0] trk_valid_q, trk_valid_d;
  logic [TRK_DEPTH-1:0] trk_pv_q;
  logic [TAG_WIDTH-1:0] trk_tag_q  [TRK_DEPTH];
  logic [RAS_WIDTH-1:0] trk_addr_q [TRK_DEPTH];
  logic                 misp_q, misp_d;
  logic [RAS_WIDTH-1:0] redir_q, redir_d;

  logic                 jal_rdy, jr_rdy, jal_acc, jr_acc;
  logic                 pred_valid, trk_full;
  logic [RAS_WIDTH-1:0] pred_addr;
  logic [SlotW-1:0]     alloc_idx, hit_idx;
  logic                 alloc_ok, hit, resolve;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  // FSM next state: flush (re)enters recovery from either state
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    if (bus.cdb_flush) begin
      state_d = StRecover;
      rc_d    = RcW'(RECOVER_CYC - 1);
    end else if (state_q == StRecover) begin
      if (rc_q == '0) state_d = StRun;
      else            rc_d    = rc_q - 1'b1;
    end
  end

  // FSM outputs; jal has priority over jr31, and nothing is accepted alongside a flush
  always_comb begin
    jal_rdy    = (state_q == StRun) & ~bus.cdb_flush;
    jr_rdy     = jal_rdy & ~trk_full & ~bus.du_jal_req;
    jal_acc    = bus.du_jal_req & jal_rdy & ~reset;
    jr_acc     = bus.du_jr31_req & jr_rdy & ~reset;
    pred_valid = (cnt_q != '0);
    pred_addr  = pred_valid ? bus.ras_top_dout : '0;

    bus.du_jal_ready       = jal_rdy;
    bus.du_jr31_ready      = jr_rdy;
    bus.du_jr31_pred_valid = pred_valid;
    bus.du_jr31_pred_addr  = pred_addr;
    bus.ras_push           = jal_acc;
    bus.ras_push_din       = bus.du_jal_ret_addr;
    bus.ras_pop            = jr_acc & pred_valid;
    bus.ctrl_mispredict    = misp_q;
    bus.ctrl_redirect_addr = redir_q;
    bus.ctrl_trk_full      = trk_full;
  end

  assign trk_full = &trk_valid_q;

  // Lowest free slot for allocation and CDB tag match, both on start-of-cycle valids
  always_comb begin
    alloc_idx = '0;
    alloc_ok  = 1'b0;
    hit_idx   = '0;
    hit       = 1'b0;
    for (int i = 0; i < int'(TRK_DEPTH); i++) begin
      if (!trk_valid_q[i] && !alloc_ok) begin
        alloc_idx = SlotW'(i);
        alloc_ok  = 1'b1;
      end
      if (trk_valid_q[i] && !hit && (trk_tag_q[i] == bus.cdb_jr31_rob_tag)) begin
        hit_idx = SlotW'(i);
        hit     = 1'b1;
      end
    end
  end

  always_comb begin
    resolve = bus.cdb_jr31_valid & hit & ~bus.cdb_flush;
    misp_d  = resolve &
              (~trk_pv_q[hit_idx] | (trk_addr_q[hit_idx] != bus.cdb_jr31_target));
    redir_d = misp_d ? bus.cdb_jr31_target : redir_q;

    trk_valid_d = trk_valid_q;
    if (bus.cdb_flush) begin
      trk_valid_d = '0;
    end else begin
      if (resolve)             trk_valid_d[hit_idx]   = 1'b0;
      if (jr_acc && alloc_ok)  trk_valid_d[alloc_idx] = 1'b1;
    end

    // Saturate at RAS_DEPTH: a push into a full ras overwrites the oldest entry
    cnt_d = cnt_q;
    if (jal_acc) begin
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (jr_acc && pred_valid) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      trk_valid_q <= '0;
      misp_q      <= 1'b0;
      redir_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      trk_valid_q <= trk_valid_d;
      misp_q      <= misp_d;
      redir_q     <= redir_d;
    end
  end

  // Slot payload is only meaningful while its valid bit is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (jr_acc && alloc_ok) begin
      trk_tag_q[alloc_idx]  <= bus.du_jr31_rob_tag;
      trk_addr_q[alloc_idx] <= pred_addr;
      trk_pv_q[alloc_idx]   <= pred_valid;
    end
  end

endmodule
